// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle controller and its datapath/memory.
// Handshake: mem_req is held high in a wait state until mem_ready is seen high on a rising clk edge.
interface mc_ctrl_fsm_if;
    logic [6:0] opcode;
    logic       mem_ready;
    logic [1:0] aluOP;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic       branch;
    logic       PC_update;
    logic       IRWrite;
    logic       AdrSrc;
    logic       memWrite;
    logic       regWrite;
    logic       mem_req;
    logic       trap;
    logic [1:0] trap_cause;
    logic       halted;

    modport master (
        input  opcode, mem_ready,
        output aluOP, resultSrc, aluSrcA, aluSrcB, branch, PC_update, IRWrite,
               AdrSrc, memWrite, regWrite, mem_req, trap, trap_cause, halted
    );

    modport slave (
        output opcode, mem_ready,
        input  aluOP, resultSrc, aluSrcA, aluSrcB, branch, PC_update, IRWrite,
               AdrSrc, memWrite, regWrite, mem_req, trap, trap_cause, halted
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32 control FSM with memory wait states, access timeout and trap/halt.
// dbg_state exposes the raw state encoding below.
module mc_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter bit          SYS_TRAP_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rstn,
    mc_ctrl_fsm_if.master bus,
    output logic [3:0]    dbg_state
);
    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEM_ADR = 4'd2,  S_MEM_READ = 4'd3;
    localparam logic [3:0] S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7;
    localparam logic [3:0] S_ALU_WB = 4'd8, S_JAL = 4'd9,     S_BRANCH = 4'd10,  S_LUI = 4'd11;
    localparam logic [3:0] S_AUIPC = 4'd12, S_JALR = 4'd13,   S_TRAP = 4'd14,    S_HALT = 4'd15;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int unsigned     CNT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(MEM_TIMEOUT);
    localparam bit               TO_EN   = (MEM_TIMEOUT > 0);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             is_wait;
    logic             timeout;

    assign is_wait = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign timeout = TO_EN && is_wait && !bus.mem_ready && (cnt_q == CNT_TO);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    OP_JALR:           state_d = S_JALR;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = (bus.opcode == OP_SYSTEM && SYS_TRAP_EN) ? 2'b11 : 2'b01;
                    end
                endcase
            end
            // The IR can only hold a load or store here; anything else is treated as illegal.
            S_MEM_ADR: begin
                if (bus.opcode == OP_LOAD) begin
                    state_d = S_MEM_READ;
                end else if (bus.opcode == OP_STORE) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end
            end
            S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_JAL, S_LUI, S_AUIPC, S_JALR: state_d = S_ALU_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH: state_d = S_FETCH;
            S_TRAP:      state_d = S_HALT;
            default:     state_d = S_HALT;
        endcase
        if (timeout) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
        end
    end

    // Counter restarts on every state change, so it is zero on entry to each wait state.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (is_wait && !bus.mem_ready && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        bus.aluOP     = 2'b00;
        bus.resultSrc = 2'b00;
        bus.aluSrcA   = 2'b00;
        bus.aluSrcB   = 2'b00;
        bus.branch    = 1'b0;
        bus.PC_update = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.memWrite  = 1'b0;
        bus.regWrite  = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.resultSrc = 2'b10; bus.aluSrcA = 2'b10; bus.aluSrcB = 2'b10;
                bus.IRWrite   = bus.mem_ready;
                bus.PC_update = bus.mem_ready;
            end
            S_DECODE:    begin bus.aluSrcA = 2'b01; bus.aluSrcB = 2'b01; end
            S_MEM_ADR:   bus.aluSrcB = 2'b01;
            S_MEM_READ:  begin bus.aluSrcA = 2'b10; bus.aluSrcB = 2'b10; bus.AdrSrc = 1'b1; end
            S_MEM_WRITE: begin
                bus.aluSrcA = 2'b10; bus.aluSrcB = 2'b10;
                bus.AdrSrc  = 1'b1;  bus.memWrite = 1'b1;
            end
            S_MEM_WB: begin
                bus.resultSrc = 2'b01; bus.aluSrcA = 2'b10; bus.aluSrcB = 2'b10;
                bus.regWrite  = 1'b1;
            end
            S_EXEC_R:    bus.aluOP = 2'b10;
            S_EXEC_I:    begin bus.aluOP = 2'b10; bus.aluSrcB = 2'b01; end
            S_JAL:       begin bus.aluSrcA = 2'b01; bus.aluSrcB = 2'b10; bus.PC_update = 1'b1; end
            S_BRANCH:    begin bus.aluOP = 2'b01; bus.branch = 1'b1; end
            S_LUI:       begin bus.aluSrcA = 2'b11; bus.aluSrcB = 2'b01; end
            S_AUIPC:     begin bus.aluSrcA = 2'b01; bus.aluSrcB = 2'b01; end
            S_JALR:      begin bus.aluSrcB = 2'b01; bus.PC_update = 1'b1; end
            S_ALU_WB:    bus.regWrite = 1'b1;
            default:     ;
        endcase
    end

    assign bus.mem_req    = is_wait;
    assign bus.trap       = (state_q == S_TRAP);
    assign bus.halted     = (state_q == S_HALT);
    assign bus.trap_cause = cause_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: default DUT plus a MEM_TIMEOUT=0 / SYS_TRAP_EN=0 twin on shared inputs.
module tb_mc_ctrl_fsm;
    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1, S_MEM_ADR = 4'd2, S_MEM_READ = 4'd3;
    localparam logic [3:0] S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_EXEC_R = 4'd6;
    localparam logic [3:0] S_ALU_WB = 4'd8, S_JAL = 4'd9, S_BRANCH = 4'd10, S_TRAP = 4'd14, S_HALT = 4'd15;
    localparam logic [6:0] OP_ADD = 7'b0110011, OP_LW = 7'b0000011, OP_SW = 7'b0100011;
    localparam logic [6:0] OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011, OP_SYS = 7'b1110011;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic [3:0] dbg_state, dbg_state0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] exp_q[$];

    mc_ctrl_fsm_if bus ();
    mc_ctrl_fsm_if bus0 ();

    assign bus0.opcode    = bus.opcode;
    assign bus0.mem_ready = bus.mem_ready;

    mc_ctrl_fsm dut (.clk(clk), .rstn(rstn), .bus(bus.master), .dbg_state(dbg_state));
    mc_ctrl_fsm #(.MEM_TIMEOUT(0), .SYS_TRAP_EN(1'b0)) dut0 (
        .clk(clk), .rstn(rstn), .bus(bus0.master), .dbg_state(dbg_state0));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic set_ready(input logic v);
        bus.mem_ready = v;
        #1;
    endtask

    task automatic do_reset(input logic rdy, input logic [6:0] op);
        @(negedge clk);
        rstn = 1'b0;
        bus.mem_ready = rdy;
        bus.opcode = op;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
    endtask

    initial begin
        logic [3:0] e;
        bus.opcode = OP_ADD;
        bus.mem_ready = 1'b1;
        #2 rstn = 1'b0;
        #1;
        check_eq("rst_state", dbg_state, S_FETCH);
        check_eq("rst_mem_req", bus.mem_req, 1);
        check_eq("rst_cause", bus.trap_cause, 0);
        check_eq("rst_halted", bus.halted, 0);

        // ADD with memory always ready
        do_reset(1'b1, OP_ADD);
        check_eq("add_irwrite", bus.IRWrite, 1);
        check_eq("add_pcupd", bus.PC_update, 1);
        exp_q = '{S_FETCH, S_DECODE, S_EXEC_R, S_ALU_WB, S_FETCH};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("add_state", dbg_state, e);
            check_eq("add_regwrite", bus.regWrite, (e == S_ALU_WB));
            if (e == S_EXEC_R) check_eq("add_aluop", bus.aluOP, 2'b10);
            if (exp_q.size() > 0) cyc();
        end

        // LW with three stall cycles in MEM_READ
        do_reset(1'b1, OP_LW);
        cyc();
        check_eq("lw_decode", dbg_state, S_DECODE);
        cyc();
        check_eq("lw_memadr", dbg_state, S_MEM_ADR);
        check_eq("lw_adr_srcb", bus.aluSrcB, 2'b01);
        for (int i = 0; i < 4; i++) begin
            cyc();
            set_ready(i == 3);
            check_eq("lw_read_state", dbg_state, S_MEM_READ);
            check_eq("lw_adrsrc", bus.AdrSrc, 1);
            check_eq("lw_mem_req", bus.mem_req, 1);
        end
        cyc();
        check_eq("lw_wb_state", dbg_state, S_MEM_WB);
        check_eq("lw_resultsrc", bus.resultSrc, 2'b01);
        check_eq("lw_wb_regwrite", bus.regWrite, 1);
        check_eq("lw_wb_adrsrc", bus.AdrSrc, 0);

        // JAL and BEQ paths
        do_reset(1'b1, OP_JAL);
        cyc();
        cyc();
        check_eq("jal_state", dbg_state, S_JAL);
        check_eq("jal_pcupd", bus.PC_update, 1);
        check_eq("jal_srcb", bus.aluSrcB, 2'b10);
        cyc();
        check_eq("jal_wb", dbg_state, S_ALU_WB);
        do_reset(1'b1, OP_BEQ);
        cyc();
        cyc();
        check_eq("beq_state", dbg_state, S_BRANCH);
        check_eq("beq_branch", bus.branch, 1);
        check_eq("beq_aluop", bus.aluOP, 2'b01);
        cyc();
        check_eq("beq_fetch", dbg_state, S_FETCH);

        // Fetch never completes: 16 FETCH cycles, then TRAP cause 10, then HALT
        do_reset(1'b0, OP_ADD);
        for (int i = 0; i < 16; i++) begin
            check_eq("to_fetch", dbg_state, S_FETCH);
            cyc();
        end
        check_eq("to_trap_state", dbg_state, S_TRAP);
        check_eq("to_trap", bus.trap, 1);
        check_eq("to_cause", bus.trap_cause, 2'b10);
        check_eq("to_mem_req", bus.mem_req, 0);
        check_eq("to0_state", dbg_state0, S_FETCH);
        check_eq("to0_trap", bus0.trap, 0);
        cyc();
        check_eq("to_halt_state", dbg_state, S_HALT);
        check_eq("to_halted", bus.halted, 1);
        check_eq("to_trap_low", bus.trap, 0);
        check_eq("to_cause_held", bus.trap_cause, 2'b10);
        for (int i = 0; i < 8; i++) cyc();
        check_eq("to0_no_trap", dbg_state0, S_FETCH);

        // Ready arrives exactly when the counter hits the limit
        do_reset(1'b0, OP_ADD);
        for (int i = 0; i < 15; i++) cyc();
        set_ready(1'b1);
        check_eq("lim_fetch", dbg_state, S_FETCH);
        check_eq("lim_irwrite", bus.IRWrite, 1);
        cyc();
        check_eq("lim_decode", dbg_state, S_DECODE);
        check_eq("lim_no_trap", bus.trap_cause, 0);

        // Illegal opcode, then reset out of HALT
        do_reset(1'b1, 7'b1111111);
        cyc();
        cyc();
        check_eq("ill_trap", bus.trap, 1);
        check_eq("ill_cause", bus.trap_cause, 2'b01);
        cyc();
        check_eq("ill_halted", bus.halted, 1);
        check_eq("ill_hold", bus.trap_cause, 2'b01);
        rstn = 1'b0;
        #1;
        check_eq("halt_rst_state", dbg_state, S_FETCH);
        check_eq("halt_rst_cause", bus.trap_cause, 0);
        check_eq("halt_rst_halted", bus.halted, 0);

        // SYSTEM: traps with cause 11, illegal on the SYS_TRAP_EN=0 twin
        do_reset(1'b1, OP_SYS);
        cyc();
        cyc();
        check_eq("sys_state", dbg_state, S_TRAP);
        check_eq("sys_cause", bus.trap_cause, 2'b11);
        check_eq("sys0_trap", bus0.trap, 1);
        check_eq("sys0_cause", bus0.trap_cause, 2'b01);

        // Reset asserted while a store is stalled
        do_reset(1'b1, OP_SW);
        cyc();
        cyc();
        set_ready(1'b0);
        cyc();
        check_eq("sw_state", dbg_state, S_MEM_WRITE);
        check_eq("sw_memwrite", bus.memWrite, 1);
        cyc();
        check_eq("sw_memwrite2", bus.memWrite, 1);
        rstn = 1'b0;
        #1;
        check_eq("sw_rst_memwrite", bus.memWrite, 0);
        check_eq("sw_rst_state", dbg_state, S_FETCH);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check_eq("sw_rel_state", dbg_state, S_FETCH);
        check_eq("sw_rel_cause", bus.trap_cause, 0);
        check_eq("sw_rel_mem_req", bus.mem_req, 1);
        set_ready(1'b1);
        cyc();
        check_eq("sw_rel_decode", dbg_state, S_DECODE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
